// File: rtl/seg_scan.sv
// Time-multiplexed seven-segment scanner with frame-aligned value commit.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan #(
   parameter int DIGITS     = 4,
   parameter int CLK_DIV    = 50000,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  load,
   output logic [7:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_done
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [7:0]        SEG_OFF  = {8{ACTIVE_LOW}};
   localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{ACTIVE_LOW}};

   // segments a..g for one hex nibble; dp is appended separately
   function automatic logic [6:0] glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'h7E;
         4'h1: g = 7'h30;
         4'h2: g = 7'h6D;
         4'h3: g = 7'h79;
         4'h4: g = 7'h33;
         4'h5: g = 7'h5B;
         4'h6: g = 7'h5F;
         4'h7: g = 7'h70;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h7B;
         4'hA: g = 7'h77;
         4'hB: g = 7'h1F;
         4'hC: g = 7'h0D;
         4'hD: g = 7'h3D;
         4'hE: g = 7'h4F;
         default: g = 7'h47;
      endcase
      return g;
   endfunction

   logic [DIV_W-1:0]    div_cnt;
   logic [IDX_W-1:0]    idx;
   logic [4*DIGITS-1:0] pend_value;
   logic [DIGITS-1:0]   pend_dp;
   logic                pend_valid;
   logic [4*DIGITS-1:0] disp_value;
   logic [DIGITS-1:0]   disp_dp;

   logic                slot_end;
   logic                frame_end;
   logic [3:0]          cur_nib;
   logic                cur_dp;
   logic                cur_blank;
   logic [DIGITS-1:0]   blank;
   logic [7:0]          seg_p0;
   logic [DIGITS-1:0]   an_p0;
`ifdef SEG_SCAN_LZB_EN
   logic                zero_run;
`endif

   assign slot_end  = (div_cnt == DIV_LAST);
   assign frame_end = slot_end && (idx == IDX_LAST);

   // ---- stage p0: slot/digit counters and display registers ----
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         idx     <= '0;
      end else if (slot_end) begin
         div_cnt <= '0;
         idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // A load landing on the frame's last cycle bypasses pend so it shows next frame
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_value <= '0;
         pend_dp    <= '0;
         pend_valid <= 1'b0;
         disp_value <= '0;
         disp_dp    <= '0;
      end else begin
         if (load) begin
            pend_value <= value;
            pend_dp    <= dp;
         end
         if (frame_end) begin
            if (load) begin
               disp_value <= value;
               disp_dp    <= dp;
            end else if (pend_valid) begin
               disp_value <= pend_value;
               disp_dp    <= pend_dp;
            end
            pend_valid <= 1'b0;
         end else if (load) begin
            pend_valid <= 1'b1;
         end
      end
   end

   // Blank a digit only if it and every more-significant nibble are zero
   always_comb begin
      blank = '0;
`ifdef SEG_SCAN_LZB_EN
      zero_run = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         zero_run = zero_run && (disp_value[4*i +: 4] == 4'h0);
         blank[i] = zero_run && !disp_dp[i];
      end
`endif
   end

   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (int'(idx) == i) begin
            cur_nib   = disp_value[4*i +: 4];
            cur_dp    = disp_dp[i];
            cur_blank = blank[i];
         end
      end
   end

   always_comb begin
      an_p0 = '0;
      for (int i = 0; i < DIGITS; i++) begin
         an_p0[i] = (div_cnt != '0) && (int'(idx) == i);
      end
      if ((div_cnt == '0) || cur_blank) begin
         seg_p0 = 8'h00;
      end else begin
         seg_p0 = {glyph(cur_nib), cur_dp};
      end
   end

   // ---- stage p1: registered pin drivers ----
   always_ff @(posedge clk) begin
      if (rst) begin
         seg        <= SEG_OFF;
         an         <= AN_OFF;
         frame_done <= 1'b0;
      end else begin
         seg        <= ACTIVE_LOW ? ~seg_p0 : seg_p0;
         an         <= ACTIVE_LOW ? ~an_p0 : an_p0;
         frame_done <= frame_end;
      end
   end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: directed frames plus random loads/resets against a frame-arithmetic model.
module tb_seg_scan;

   localparam int DIGITS  = 4;
   localparam int CLK_DIV = 4;
   localparam int FRAME   = DIGITS * CLK_DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] value = '0;
   logic [3:0]  dp = '0;
   logic        load = 1'b0;
   logic [7:0]  seg, seg_al;
   logic [3:0]  an, an_al;
   logic        frame_done, fd_al;

   int n_assert = 0;
   int n_fail   = 0;

   // model state: position within frame as one number, plus shown/pending values
   int          tick = 0;
   logic [15:0] dval = '0;
   logic [3:0]  ddp = '0;
   logic [15:0] pval = '0;
   logic [3:0]  pdp = '0;
   bit          pvalid = 1'b0;
   logic [7:0]  glyph_tab [16];

   seg_scan #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .ACTIVE_LOW(1'b0)) u_dut (
      .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load),
      .seg(seg), .an(an), .frame_done(frame_done));

   seg_scan #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .ACTIVE_LOW(1'b1)) u_dut_al (
      .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load),
      .seg(seg_al), .an(an_al), .frame_done(fd_al));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_out(input int t, input logic [15:0] v, input logic [3:0] d,
                                     output logic [7:0] s, output logic [3:0] a);
      int pos = t % CLK_DIV;
      int dig = t / CLK_DIV;
      logic [15:0] upper;
      s = 8'h00;
      a = 4'h0;
      if (pos != 0) begin
         a = 4'(1 << dig);
         upper = v >> (4 * dig);
         s = {glyph_tab[upper[3:0]][7:1], d[dig]};
`ifdef SEG_SCAN_LZB_EN
         if (dig > 0 && upper == 16'h0 && !d[dig]) s = 8'h00;
`endif
      end
   endfunction

   // one clock: predict, advance model, check both instances
   task automatic step();
      logic [7:0] es, inv_s;
      logic [3:0] ea, inv_a;
      logic       ef;
      if (rst) begin
         es = 8'h00; ea = 4'h0; ef = 1'b0;
         tick = 0; dval = '0; ddp = '0; pval = '0; pdp = '0; pvalid = 1'b0;
      end else begin
         model_out(tick, dval, ddp, es, ea);
         ef = (tick == FRAME - 1);
         if (ef && load) begin
            dval = value; ddp = dp; pvalid = 1'b0;
         end else if (ef && pvalid) begin
            dval = pval; ddp = pdp; pvalid = 1'b0;
         end else if (load) begin
            pval = value; pdp = dp; pvalid = 1'b1;
         end
         tick = (tick + 1) % FRAME;
      end
      inv_s = ~es;
      inv_a = ~ea;
      @(posedge clk);
      #1;
      check("seg", 32'(seg), 32'(es));
      check("an", 32'(an), 32'(ea));
      check("frame_done", 32'(frame_done), 32'(ef));
      check("seg_al", 32'(seg_al), 32'(inv_s));
      check("an_al", 32'(an_al), 32'(inv_a));
      check("frame_done_al", 32'(fd_al), 32'(ef));
   endtask

   task automatic wait_fd();
      bit seen = 1'b0;
      for (int i = 0; i < 3 * FRAME && !seen; i++) begin
         step();
         if (frame_done === 1'b1) seen = 1'b1;
      end
      check("fd_wait", 32'(seen), 32'd1);
   endtask

   // Entered when the next edge starts a frame; segs = {d3,d2,d1,d0}
   task automatic expect_frame(input string tag, input logic [31:0] segs);
      logic [7:0] s;
      logic [3:0] a;
      for (int d = 0; d < DIGITS; d++) begin
         step();
         check({tag, "_ghost_an"}, 32'(an), 32'd0);
         s = segs[8*d +: 8];
         a = 4'(1 << d);
         for (int j = 0; j < CLK_DIV - 1; j++) begin
            step();
            check({tag, "_an"}, 32'(an), 32'(a));
            check({tag, "_seg"}, 32'(seg), 32'(s));
         end
      end
   endtask

   initial begin
      int pulses;
      glyph_tab = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E};

      // reset state
      rst = 1'b1;
      repeat (3) step();
      check("rst_an", 32'(an), 32'd0);
      check("rst_seg", 32'(seg), 32'd0);
      check("rst_an_al", 32'(an_al), 32'hF);
      check("rst_seg_al", 32'(seg_al), 32'hFF);
      rst = 1'b0;
      expect_frame("boot", {8'hFC, 8'hFC, 8'hFC, 8'hFC});

      // scan order
      value = 16'h1234; dp = 4'b0100; load = 1'b1;
      step();
      load = 1'b0;
      wait_fd();
      expect_frame("scan", {8'h60, 8'hDB, 8'hF2, 8'h66});

      // mid-frame load held until the boundary
      repeat (6) step();
      value = 16'hABCD; dp = 4'b0000; load = 1'b1;
      step();
      load = 1'b0;
      wait_fd();
      expect_frame("abcd", {8'hEE, 8'h3E, 8'h1A, 8'h7A});

      pulses = 0;
      for (int i = 0; i < 4 * FRAME; i++) begin
         step();
         if (frame_done === 1'b1) pulses++;
      end
      check("fd_count", 32'(pulses), 32'd4);

      // two loads in one frame: last wins
      repeat (2) step();
      value = 16'h1111; load = 1'b1;
      step();
      load = 1'b0;
      repeat (3) step();
      value = 16'h2222; load = 1'b1;
      step();
      load = 1'b0;
      wait_fd();
      expect_frame("overwrite", {8'hDA, 8'hDA, 8'hDA, 8'hDA});

      // load exactly on the commit cycle
      repeat (FRAME - 1) step();
      value = 16'h5678; load = 1'b1;
      step();
      load = 1'b0;
      check("commit_fd", 32'(frame_done), 32'd1);
      expect_frame("commit_load", {8'hB6, 8'hBE, 8'hE0, 8'hFE});

      // leading zeros
      value = 16'h0050; dp = 4'b0000; load = 1'b1;
      step();
      load = 1'b0;
      wait_fd();
`ifdef SEG_SCAN_LZB_EN
      expect_frame("lzb", {8'h00, 8'h00, 8'hB6, 8'hFC});
`else
      expect_frame("lzb", {8'hFC, 8'hFC, 8'hB6, 8'hFC});
`endif

      // reset during slot 2 with a load pending
      repeat (5) step();
      value = 16'hDEAD; dp = 4'b1111; load = 1'b1;
      step();
      load = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      step();
      check("midrst_an_al", 32'(an_al), 32'hF);
      check("midrst_seg_al", 32'(seg_al), 32'hFF);
      check("midrst_an", 32'(an), 32'h0);
      rst = 1'b0;
      expect_frame("postrst0", {8'hFC, 8'hFC, 8'hFC, 8'hFC});
      expect_frame("postrst1", {8'hFC, 8'hFC, 8'hFC, 8'hFC});

      // random loads and occasional resets
      for (int i = 0; i < 400; i++) begin
         load  = !load && ($urandom_range(0, 5) == 0);
         value = 16'($urandom);
         if ($urandom_range(0, 2) == 0) value[15:8] = 8'h00;
         dp    = 4'($urandom);
         rst   = ($urandom_range(0, 99) == 0);
         step();
      end
      load = 1'b0;
      rst  = 1'b0;
      repeat (FRAME + 2) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
